// File: rtl/mem_exerciser_pkg.sv
// Shared states, counter widths and the test-pattern function for
// the memory exerciser.
package mem_exerciser_pkg;

  localparam int ERR_W = 16;
  localparam int CYC_W = 32;
  localparam int PAT_W = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_ISSUE,
    S_W_GAP,
    S_W_WAIT,
    S_R_ISSUE,
    S_R_GAP,
    S_R_WAIT,
    S_DONE
  } state_e;

  function automatic logic [PAT_W-1:0] pat_data(
    input logic [PAT_W-1:0] addr,
    input logic             odd,
    input logic [PAT_W-1:0] pattern
  );
    return addr ^ (odd ? ~pattern : pattern);
  endfunction

endpackage

// File: rtl/mem_exerciser_if.sv
// Memory port bundle: addr/dout/re/we towards memory,
// din/ready back.
interface mem_exerciser_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int WORD_WIDTH = 64
);

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WORD_WIDTH-1:0] mem_dout;
  logic [WORD_WIDTH-1:0] mem_din;
  logic                  mem_re;
  logic                  mem_we;
  logic                  mem_ready;

  modport master (
    output mem_addr, mem_dout, mem_re, mem_we,
    input  mem_din, mem_ready
  );

  modport slave (
    input  mem_addr, mem_dout, mem_re, mem_we,
    output mem_din, mem_ready
  );

endinterface

// File: rtl/mem_exerciser_watchdog.sv
// Wait-state watchdog: cleared by load, counts stalled cycles,
// flags the TIMEOUT-th one.
module mem_exerciser_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic count_i,
  output logic expire_o
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign expire_o = count_i && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = '0;
    else if (count_i && !expire_o)
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mem_exerciser.sv
// Memory traffic generator/checker: write sweep, read-back compare.
// Optional: MEM_EXERCISER_STOP_ON_ERROR_EN ends the run on first mismatch.
module mem_exerciser
  import mem_exerciser_pkg::*;
#(
  parameter int          ADDR_WIDTH = 64,
  parameter int          WORD_WIDTH = 64,
  parameter logic [63:0] BASE_ADDR  = 64'd0,
  parameter logic [63:0] STRIDE     = 64'd1,
  parameter int          COUNT      = 16,
  parameter int          PASSES     = 1,
  parameter logic [63:0] PATTERN    = 64'h0123456789abcdef,
  parameter int          TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  mem_exerciser_if.master       mem,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [ERR_W-1:0]      err_count,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic [WORD_WIDTH-1:0] err_expected,
  output logic [WORD_WIDTH-1:0] err_actual,
  output logic [CYC_W-1:0]      cycles
);

  localparam int IW = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(STRIDE);
  localparam logic [IW-1:0] LAST_I = IW'(COUNT - 1);
  localparam logic [PW-1:0] LAST_P = PW'(PASSES - 1);

  state_e                state_q, state_d;
  logic [IW-1:0]         i_q, i_d;
  logic [PW-1:0]         p_q, p_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic                  tmo_q, tmo_d;
  logic [ERR_W-1:0]      ecnt_q, ecnt_d;
  logic [ADDR_WIDTH-1:0] eaddr_q, eaddr_d;
  logic [WORD_WIDTH-1:0] eexp_q, eexp_d;
  logic [WORD_WIDTH-1:0] eact_q, eact_d;
  logic [CYC_W-1:0]      cyc_q, cyc_d;

  logic [WORD_WIDTH-1:0] exp_data;
  logic                  mismatch;
  logic                  we, re;
  logic                  wd_load, wd_count, wd_expire;
  logic                  finish, stop_now;

  assign exp_data = WORD_WIDTH'(pat_data(PAT_W'(addr_q), p_q[0], PATTERN));
  assign mismatch = (mem.mem_din != exp_data);

  // Bus is forced to zero outside a run so reset leaves it quiet.
  assign mem.mem_addr = busy_q ? addr_q : '0;
  assign mem.mem_dout = busy_q ? exp_data : '0;
  assign mem.mem_we   = we;
  assign mem.mem_re   = re;

  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign timeout      = tmo_q;
  assign err_count    = ecnt_q;
  assign err_addr     = eaddr_q;
  assign err_expected = eexp_q;
  assign err_actual   = eact_q;
  assign cycles       = cyc_q;

  mem_exerciser_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wd (
    .clk      (clk),
    .rst_n    (rst),
    .load_i   (wd_load),
    .count_i  (wd_count),
    .expire_o (wd_expire)
  );

  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    p_d      = p_q;
    addr_d   = addr_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    tmo_d    = tmo_q;
    ecnt_d   = ecnt_q;
    eaddr_d  = eaddr_q;
    eexp_d   = eexp_q;
    eact_d   = eact_q;
    cyc_d    = cyc_q;
    we       = 1'b0;
    re       = 1'b0;
    wd_load  = 1'b0;
    wd_count = 1'b0;
    finish   = 1'b0;
    stop_now = 1'b0;

    if (busy_q && cyc_q != '1)
      cyc_d = cyc_q + CYC_W'(1);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_W_ISSUE;
          i_d     = '0;
          p_d     = '0;
          addr_d  = BASE;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          tmo_d   = 1'b0;
          ecnt_d  = '0;
          eaddr_d = '0;
          eexp_d  = '0;
          eact_d  = '0;
          cyc_d   = '0;
        end
      end
      S_W_ISSUE: begin
        if (mem.mem_ready) begin
          we      = 1'b1;
          state_d = S_W_GAP;
        end
      end
      S_W_GAP: begin
        wd_load = 1'b1;
        state_d = S_W_WAIT;
      end
      S_W_WAIT: begin
        if (mem.mem_ready) begin
          if (i_q == LAST_I) begin
            i_d     = '0;
            addr_d  = BASE;
            state_d = S_R_ISSUE;
          end else begin
            i_d     = i_q + IW'(1);
            addr_d  = addr_q + STEP;
            state_d = S_W_ISSUE;
          end
        end else begin
          wd_count = 1'b1;
          if (wd_expire) begin
            tmo_d  = 1'b1;
            finish = 1'b1;
          end
        end
      end
      S_R_ISSUE: begin
        if (mem.mem_ready) begin
          re      = 1'b1;
          state_d = S_R_GAP;
        end
      end
      S_R_GAP: begin
        wd_load = 1'b1;
        state_d = S_R_WAIT;
      end
      S_R_WAIT: begin
        if (mem.mem_ready) begin
          if (mismatch) begin
            if (ecnt_q != '1)
              ecnt_d = ecnt_q + ERR_W'(1);
            if (ecnt_q == '0) begin
              eaddr_d = addr_q;
              eexp_d  = exp_data;
              eact_d  = mem.mem_din;
            end
          end
`ifdef MEM_EXERCISER_STOP_ON_ERROR_EN
          stop_now = mismatch;
`else
          stop_now = 1'b0;
`endif
          if (stop_now) begin
            finish = 1'b1;
          end else if (i_q == LAST_I) begin
            if (p_q == LAST_P) begin
              finish = 1'b1;
            end else begin
              p_d     = p_q + PW'(1);
              i_d     = '0;
              addr_d  = BASE;
              state_d = S_W_ISSUE;
            end
          end else begin
            i_d     = i_q + IW'(1);
            addr_d  = addr_q + STEP;
            state_d = S_R_ISSUE;
          end
        end else begin
          wd_count = 1'b1;
          if (wd_expire) begin
            tmo_d  = 1'b1;
            finish = 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (finish) begin
      state_d = S_DONE;
      busy_d  = 1'b0;
      done_d  = 1'b1;
      pass_d  = !tmo_d && (ecnt_d == '0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      p_q     <= '0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      tmo_q   <= 1'b0;
      ecnt_q  <= '0;
      eaddr_q <= '0;
      eexp_q  <= '0;
      eact_q  <= '0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      p_q     <= p_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      tmo_q   <= tmo_d;
      ecnt_q  <= ecnt_d;
      eaddr_q <= eaddr_d;
      eexp_q  <= eexp_d;
      eact_q  <= eact_d;
      cyc_q   <= cyc_d;
    end
  end

endmodule

// File: tb/tb_mem_exerciser.sv
// Bench for mem_exerciser: random-latency memory model, access log
// checked against a sequence derived from the address/data rules.
module tb_mem_exerciser;

  localparam int          AW      = 64;
  localparam int          WW      = 64;
  localparam logic [63:0] BASE    = 64'd1;
  localparam logic [63:0] STRIDE  = 64'd256;
  localparam logic [63:0] PAT     = 64'h0123456789abcdef;
  localparam int          COUNT   = 4;
  localparam int          PASSES  = 2;
  localparam int          TIMEOUT = 1024;

  typedef struct {
    bit          w;
    logic [63:0] a;
    logic [63:0] d;
    int          c;
  } acc_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy, done, pass_o, timeout;
  logic [15:0]   err_count;
  logic [AW-1:0] err_addr;
  logic [WW-1:0] err_expected, err_actual;
  logic [31:0]   cycles;

  int checks = 0;
  int passed = 0;
  int cyc = 0;

  acc_t log_q[$];
  acc_t exp_q[$];
  logic [63:0] mem [logic [63:0]];

  bit          stall_mode   = 0;
  bit          stall_active = 0;
  int          corrupt_left = 0;
  logic [63:0] corrupt_addr = '0;
  int          bad_strobes  = 0;

  mem_exerciser_if #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW)) bus();

  mem_exerciser #(
    .ADDR_WIDTH (AW),
    .WORD_WIDTH (WW),
    .BASE_ADDR  (BASE),
    .STRIDE     (STRIDE),
    .COUNT      (COUNT),
    .PASSES     (PASSES),
    .PATTERN    (PAT),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .mem          (bus),
    .busy         (busy),
    .done         (done),
    .pass         (pass_o),
    .timeout      (timeout),
    .err_count    (err_count),
    .err_addr     (err_addr),
    .err_expected (err_expected),
    .err_actual   (err_actual),
    .cycles       (cycles)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] addr_of(input int i);
    return BASE + 64'(i) * STRIDE;
  endfunction

  function automatic logic [63:0] data_of(input int i, input int p);
    return addr_of(i) ^ (((p % 2) == 1) ? ~PAT : PAT);
  endfunction

  // Memory model: strobes seen mid-cycle, ready/din updated after the edge.
  initial begin
    logic        nr;
    logic [63:0] nd;
    bit          gap_n;
    int          low_n;
    nd = '0;
    gap_n = 0;
    low_n = 0;
    bus.mem_ready = 1'b1;
    bus.mem_din = '0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && (bus.mem_we || bus.mem_re)) begin
        if (!bus.mem_ready || (bus.mem_we && bus.mem_re))
          bad_strobes++;
        log_q.push_back('{w: bus.mem_we, a: bus.mem_addr,
                          d: bus.mem_dout, c: cyc});
        if (bus.mem_we) begin
          mem[bus.mem_addr] = bus.mem_dout;
          if (stall_mode) stall_active = 1;
        end else begin
          nd = mem.exists(bus.mem_addr) ? mem[bus.mem_addr] : '0;
          if (corrupt_left > 0 && bus.mem_addr == corrupt_addr) begin
            nd = '0;
            corrupt_left--;
          end
        end
        gap_n = 1;
        low_n = $urandom_range(0, 3);
      end
      if (stall_active) begin
        nr = 1'b0;
      end else if (gap_n) begin
        nr = 1'($urandom_range(0, 1));
        gap_n = 0;
      end else if (low_n > 0) begin
        nr = 1'b0;
        low_n--;
      end else begin
        nr = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk);
      #1;
      bus.mem_ready = nr;
      bus.mem_din = nd;
    end
  end

  task automatic build_expect(input bit c_en, input logic [63:0] c_addr,
                              output int e_errs, output logic [63:0] e_ea,
                              output logic [63:0] e_ex,
                              output logic [63:0] e_ac);
    bit left;
    logic [63:0] ret;
    exp_q.delete();
    e_errs = 0;
    e_ea = '0;
    e_ex = '0;
    e_ac = '0;
    left = c_en;
    for (int p = 0; p < PASSES; p++) begin
      for (int i = 0; i < COUNT; i++)
        exp_q.push_back('{w: 1, a: addr_of(i), d: data_of(i, p), c: 0});
      for (int i = 0; i < COUNT; i++) begin
        exp_q.push_back('{w: 0, a: addr_of(i), d: '0, c: 0});
        ret = data_of(i, p);
        if (left && addr_of(i) == c_addr) begin
          ret = '0;
          left = 0;
        end
        if (ret != data_of(i, p)) begin
          if (e_errs == 0) begin
            e_ea = addr_of(i);
            e_ex = data_of(i, p);
            e_ac = ret;
          end
          e_errs++;
`ifdef MEM_EXERCISER_STOP_ON_ERROR_EN
          return;
`endif
        end
      end
    end
  endtask

  task automatic do_run(input bit pulse, output int n, output bit ok,
                        output logic b0, output logic d0,
                        output int done_cyc);
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    b0 = busy;
    d0 = done;
    n = 0;
    ok = 0;
    done_cyc = 0;
    while (n < 5000) begin
      @(posedge clk);
      #1;
      n++;
      start = pulse && (n == 5);
      if (done) begin
        ok = 1;
        done_cyc = cyc;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, pass_o, timeout} !== 4'b0)
      $display("FAIL reset_flags got %b want 0000",
               {busy, done, pass_o, timeout});
    else passed++;
    checks++;
    if (err_count !== 16'd0 || cycles !== 32'd0)
      $display("FAIL reset_counters got %0h/%0h want 0/0",
               err_count, cycles);
    else passed++;
    checks++;
    if (err_addr !== '0 || err_expected !== '0 || err_actual !== '0)
      $display("FAIL reset_err_fields got %0h/%0h/%0h want 0",
               err_addr, err_expected, err_actual);
    else passed++;
    checks++;
    if ({bus.mem_re, bus.mem_we} !== 2'b00 || bus.mem_addr !== '0 ||
        bus.mem_dout !== '0)
      $display("FAIL reset_bus got re%b we%b a%0h d%0h want 0",
               bus.mem_re, bus.mem_we, bus.mem_addr, bus.mem_dout);
    else passed++;
    rst = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_clean_run;
    int n, dc, e_errs, sz;
    bit ok;
    logic b0, d0;
    logic [63:0] ea, ex, ac;
    log_q.delete();
    build_expect(0, '0, e_errs, ea, ex, ac);
    do_run(1, n, ok, b0, d0, dc);
    checks++;
    if (!ok) $display("FAIL clean_done got timeout want done");
    else passed++;
    checks++;
    if ({b0, d0} !== 2'b10)
      $display("FAIL clean_accept got %b want 10", {b0, d0});
    else passed++;
    checks++;
    if (log_q.size() != exp_q.size())
      $display("FAIL clean_log_len got %0d want %0d",
               log_q.size(), exp_q.size());
    else passed++;
    for (int k = 0; k < exp_q.size() && k < log_q.size(); k++) begin
      checks++;
      if (log_q[k].w !== exp_q[k].w || log_q[k].a !== exp_q[k].a ||
          (exp_q[k].w && log_q[k].d !== exp_q[k].d))
        $display("FAIL clean_acc%0d got w%0b a%0h d%0h want w%0b a%0h d%0h",
                 k, log_q[k].w, log_q[k].a, log_q[k].d,
                 exp_q[k].w, exp_q[k].a, exp_q[k].d);
      else passed++;
    end
    checks++;
    if ({pass_o, timeout, busy} !== 3'b100 || err_count !== 16'd0 ||
        err_addr !== '0)
      $display("FAIL clean_status got p%b t%b b%b e%0d ea%0h want p1 t0 b0 e0 ea0",
               pass_o, timeout, busy, err_count, err_addr);
    else passed++;
    checks++;
    if (cycles !== 32'(n))
      $display("FAIL clean_cycles got %0d want %0d", cycles, n);
    else passed++;
    // start during the DONE cycle must not launch a run
    sz = log_q.size();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, pass_o} !== 3'b011 || log_q.size() != sz)
      $display("FAIL start_in_done got b%b d%b p%b acc%0d want b0 d1 p1 acc%0d",
               busy, done, pass_o, log_q.size(), sz);
    else passed++;
    checks++;
    if (bad_strobes != 0)
      $display("FAIL strobe_rules got %0d want 0", bad_strobes);
    else passed++;
  endtask

  task automatic test_corrupt;
    int n, dc, e_errs;
    bit ok;
    logic b0, d0;
    logic [63:0] ea, ex, ac;
    log_q.delete();
    corrupt_addr = addr_of(1);
    corrupt_left = 1;
    build_expect(1, addr_of(1), e_errs, ea, ex, ac);
    do_run(0, n, ok, b0, d0, dc);
    corrupt_left = 0;
    checks++;
    if (!ok) $display("FAIL corrupt_done got timeout want done");
    else passed++;
    checks++;
    if (log_q.size() != exp_q.size())
      $display("FAIL corrupt_log_len got %0d want %0d",
               log_q.size(), exp_q.size());
    else passed++;
    for (int k = 0; k < exp_q.size() && k < log_q.size(); k++) begin
      checks++;
      if (log_q[k].w !== exp_q[k].w || log_q[k].a !== exp_q[k].a)
        $display("FAIL corrupt_acc%0d got w%0b a%0h want w%0b a%0h",
                 k, log_q[k].w, log_q[k].a, exp_q[k].w, exp_q[k].a);
      else passed++;
    end
    checks++;
    if (err_count !== 16'(e_errs) || pass_o !== 1'b0 || done !== 1'b1)
      $display("FAIL corrupt_status got e%0d p%b d%b want e%0d p0 d1",
               err_count, pass_o, done, e_errs);
    else passed++;
    checks++;
    if (err_addr !== ea || err_expected !== ex || err_actual !== ac)
      $display("FAIL corrupt_first got %0h/%0h/%0h want %0h/%0h/%0h",
               err_addr, err_expected, err_actual, ea, ex, ac);
    else passed++;
  endtask

  task automatic test_timeout;
    int n, dc, sz;
    bit ok;
    logic b0, d0;
    log_q.delete();
    stall_mode = 1;
    do_run(0, n, ok, b0, d0, dc);
    checks++;
    if (!ok || log_q.size() < 1)
      $display("FAIL timeout_done got ok%0b acc%0d want ok1 acc1",
               ok, log_q.size());
    else begin
      passed++;
      checks++;
      if (dc - log_q[0].c != TIMEOUT + 2)
        $display("FAIL timeout_latency got %0d want %0d",
                 dc - log_q[0].c, TIMEOUT + 2);
      else passed++;
    end
    checks++;
    if ({timeout, pass_o, busy} !== 3'b100 || err_count !== 16'd0)
      $display("FAIL timeout_status got t%b p%b b%b e%0d want t1 p0 b0 e0",
               timeout, pass_o, busy, err_count);
    else passed++;
    sz = log_q.size();
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (sz != 1 || log_q.size() != 1)
      $display("FAIL timeout_strobes got %0d/%0d want 1", sz, log_q.size());
    else passed++;
    stall_mode = 0;
    stall_active = 0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset_mid_run;
    int n, dc, e_errs, k;
    bit ok, found;
    logic b0, d0;
    logic [63:0] ea, ex, ac;
    log_q.delete();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    found = 0;
    k = 0;
    while (!found && k < 2000) begin
      @(posedge clk);
      #1;
      k++;
      found = (log_q.size() > 0) && (log_q[log_q.size()-1].w == 0);
    end
    checks++;
    if (!found) $display("FAIL midrst_read got none want read strobe");
    else passed++;
    // one cycle after the gap the exerciser is waiting on the read
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({busy, done, pass_o, timeout, bus.mem_re, bus.mem_we} !== 6'b0 ||
        bus.mem_addr !== '0 || bus.mem_dout !== '0 ||
        cycles !== 32'd0 || err_count !== 16'd0)
      $display("FAIL midrst_outputs got b%b d%b re%b we%b a%0h c%0d want 0",
               busy, done, bus.mem_re, bus.mem_we, bus.mem_addr, cycles);
    else passed++;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    log_q.delete();
    build_expect(0, '0, e_errs, ea, ex, ac);
    do_run(1, n, ok, b0, d0, dc);
    checks++;
    if (!ok || pass_o !== 1'b1 || log_q.size() != exp_q.size())
      $display("FAIL midrst_rerun got ok%0b p%b acc%0d want ok1 p1 acc%0d",
               ok, pass_o, log_q.size(), exp_q.size());
    else passed++;
    checks++;
    if (cycles !== 32'(n))
      $display("FAIL midrst_cycles got %0d want %0d", cycles, n);
    else passed++;
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    test_reset();
    test_clean_run();
    test_corrupt();
    test_timeout();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
